dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (dmem: 9-bit read/write addresses, 32-bit data) between two requesters:
//  requester 0 = core load/store unit, requester 1 = debug/DMA port. Round-robin arbitration, valid/ready request
//  handshake, one-cycle response pulse. Sits between the requesters and dmem; dmem is its only memory-side client.
// PARAMETERS
//  ADDR_W     9    address width, matches dmem
//  DATA_W     32   data width, matches dmem
//  MEM_DEPTH  512  valid address range [0, MEM_DEPTH-1]; used only with DMEM_ARB_BOUNDS_EN
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset_n        in   1       synchronous, active-low reset
//  reqValid[1:0]  in   2       per-requester request valid
//  reqWrite[1:0]  in   2       1 = write, 0 = read
//  reqAddr0/1     in   ADDR_W  request address, requester 0/1
//  reqWData0/1    in   DATA_W  write data, requester 0/1
//  reqReady[1:0]  out  2       request accepted this cycle (one-hot or zero)
//  rspValid[1:0]  out  2       one-cycle response pulse to the owning requester
//  rspRData       out  DATA_W  read data, valid while rspValid; 0 for writes
//  rspErr         out  1       out-of-range access flag, valid while rspValid
//  readAddress    out  ADDR_W  to dmem
//  readData       in   DATA_W  from dmem, combinational on readAddress
//  writeAddress   out  ADDR_W  to dmem
//  writeData      out  DATA_W  to dmem
//  writeEnable    out  1       to dmem, single-cycle strobe
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state IDLE, rrPtr=0, all outputs 0 (reqReady, rspValid, rspRData, rspErr,
//    readAddress, writeAddress, writeData, writeEnable). Reset mid-transaction discards it: no write, no response.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. One transaction in flight; one accept per 3 cycles max.
//  - IDLE: grant = rr pick over reqValid; rrPtr names the preferred requester. Both valid -> grant rrPtr;
//    one valid -> grant it. reqReady[grant] asserted combinationally in IDLE only; handshake = valid&ready at edge.
//    On handshake latch write/addr/wdata/owner, rrPtr <= ~owner, go ACCESS. No valid -> stay IDLE.
//  - ACCESS (cycle 1): readAddress = writeAddress = latched addr; writeData = latched wdata;
//    writeEnable = 1 iff write. Read: capture readData into rspRData at end of ACCESS. Go RESP.
//  - RESP (cycle 2): rspValid[owner]=1 for exactly this cycle; rspRData = captured data (0 for write). Go IDLE.
//  - Latency: accept edge at T -> writeEnable high in cycle T+1 -> rspValid in cycle T+2.
//  - Outside ACCESS: writeEnable=0, writeData=0, addresses hold last value (no spurious writes).
//  - reqReady is 0 in ACCESS and RESP; a requester may drop reqValid without penalty before handshake.
//  - Requester held valid continuously alternates with the other (no starvation): worst-case wait 1 transaction.
//  - rrPtr updates only on handshake; read-after-write to same addr from either requester returns new data.
// CONFIGURATION
//  - Macro DMEM_ARB_BOUNDS_EN defined: latched addr >= MEM_DEPTH -> writeEnable stays 0 in ACCESS,
//    rspRData = 0, rspErr = 1 in RESP; timing unchanged.
//  - Not defined: no range check, all addresses pass to dmem, rspErr tied 0, MEM_DEPTH unused.
// STRUCTURE
//  - Package dmem_arb_pkg: ADDR_W/DATA_W defaults, state enum {IDLE, ACCESS, RESP}, requester-id typedef.
//  - Sub-module rr_pick2: 2-way round-robin picker (valid[1:0], ptr -> grant one-hot, any); pure combinational.
//  - Top: FSM, request latch, response register, dmem drive.
// TESTING
//  - Reset: hold reset_n=0 3 cycles with reqValid=2'b11 -> all outputs 0, no reqReady, no writeEnable.
//  - Single write/read: req0 write addr 10 data 12345, then read addr 10 -> writeEnable one cycle at T+1,
//    rspValid[0] at T+2 both times, read rspRData=12345, rspErr=0.
//  - Contention: both valid from reset, req0 write 11/6789, req1 write 12/4242 -> req0 granted first, req1 next,
//    rrPtr alternates; reads of 11 and 12 return 6789 and 4242.
//  - Starvation: req0 valid continuously 10 transactions, req1 raised at txn 3 -> req1 served no later than txn 4.
//  - Reset mid-op: reset_n=0 during ACCESS of write addr 20 data 99 -> no rspValid; later read of 20 != 99
//    (pre-initialised 0 returns 0).
//  - DMEM_ARB_BOUNDS_EN, MEM_DEPTH=256: write addr 300 -> writeEnable stays 0, rspErr=1, rspRData=0;
//    without macro same stimulus writes and rspErr=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-requester data-memory arbiter.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF    = 9;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_DEPTH_DEF = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

    // Requester id: 0 = core load/store unit, 1 = debug/DMA port.
    typedef logic reqId_t;

    function automatic logic [1:0] idToOneHot(input reqId_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: ptr names the requester preferred on a tie.
// Latency: purely combinational.
// Backpressure: none; grant only reflects the current valid vector.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  reqId_t     ptr,
    output logic [1:0] grant,
    output logic       any
);

    // A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = idToOneHot(ptr);
        end else begin
            grant = valid;
        end
        any = |valid;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port dmem between the LSU (0) and debug/DMA (1); optional DMEM_ARB_BOUNDS_EN.
// Latency: accept edge T -> dmem access (writeEnable) in cycle T+1 -> rspValid pulse in cycle T+2.
// Backpressure: reqReady only in IDLE, so at most one accept every 3 cycles; dropping reqValid before accept is free.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        reqValid,
    input  logic [1:0]        reqWrite,
    input  logic [ADDR_W-1:0] reqAddr0,
    input  logic [ADDR_W-1:0] reqAddr1,
    input  logic [DATA_W-1:0] reqWData0,
    input  logic [DATA_W-1:0] reqWData1,
    output logic [1:0]        reqReady,
    output logic [1:0]        rspValid,
    output logic [DATA_W-1:0] rspRData,
    output logic              rspErr,
    output logic [ADDR_W-1:0] readAddress,
    input  logic [DATA_W-1:0] readData,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEnable
);

    arbState_t         state;
    arbState_t         stateNext;
    reqId_t            rrPtr;
    reqId_t            owner;
    logic              isWrite;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] rdataQ;
    logic              errQ;

    logic [1:0]        grant;
    logic              grantAny;
    reqId_t            grantId;
    logic              handshake;
    logic              addrErr;

    rr_pick2 u_pick (
        .valid (reqValid),
        .ptr   (rrPtr),
        .grant (grant),
        .any   (grantAny)
    );

    assign grantId = grant[1];
    // Ready is only offered in IDLE and out of reset, and grant is a subset of valid,
    // so any grant seen here is a completed handshake at the coming edge.
    assign handshake = (state == IDLE) && grantAny && reset_n;

`ifdef DMEM_ARB_BOUNDS_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
    assign addrErr = ({1'b0, addrQ} >= DEPTH_L);
`else
    logic [31:0] unusedDepth;
    assign unusedDepth = 32'(MEM_DEPTH);
    assign addrErr     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and all combinational outputs; reset_n gates the strobes so a
    // reset asserted mid-transaction suppresses the pending write and response.
    always_comb begin
        stateNext   = state;
        reqReady    = 2'b00;
        rspValid    = 2'b00;
        rspRData    = '0;
        rspErr      = 1'b0;
        writeData   = '0;
        writeEnable = 1'b0;
        case (state)
            IDLE: begin
                if (reset_n) begin
                    reqReady = grant;
                end
                if (handshake) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                if (reset_n) begin
                    writeData   = wdataQ;
                    writeEnable = isWrite && !addrErr;
                end
                stateNext = RESP;
            end
            RESP: begin
                if (reset_n) begin
                    rspValid = idToOneHot(owner);
                    rspRData = rdataQ;
                    rspErr   = errQ;
                end
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Both dmem addresses come straight from the request latch, so they hold
    // their last value between transactions.
    assign readAddress  = addrQ;
    assign writeAddress = addrQ;

    // Request latch and round-robin pointer, updated only on a handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rrPtr   <= 1'b0;
            owner   <= 1'b0;
            isWrite <= 1'b0;
            addrQ   <= '0;
            wdataQ  <= '0;
        end else if (handshake) begin
            rrPtr   <= ~grantId;
            owner   <= grantId;
            isWrite <= reqWrite[grantId];
            addrQ   <= grantId ? reqAddr1 : reqAddr0;
            wdataQ  <= grantId ? reqWData1 : reqWData0;
        end
    end

    // Response capture at the end of ACCESS: read data for in-range reads, else 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else if (state == ACCESS) begin
            rdataQ <= (isWrite || addrErr) ? '0 : readData;
            errQ   <= addrErr;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a dmem model and a response scoreboard.
// Latency: checks accept -> writeEnable at T+1 -> rspValid at T+2.
// Backpressure: drives requests until reqReady, with bounded waits.
module tb_dmem_arbiter;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        logic [1:0]    owner;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic [1:0]    reqValid;
    logic [1:0]    reqWrite;
    logic [AW-1:0] reqAddr0;
    logic [AW-1:0] reqAddr1;
    logic [DW-1:0] reqWData0;
    logic [DW-1:0] reqWData1;
    logic [1:0]    reqReady;
    logic [1:0]    rspValid;
    logic [DW-1:0] rspRData;
    logic          rspErr;
    logic [AW-1:0] readAddress;
    logic [DW-1:0] readData;
    logic [AW-1:0] writeAddress;
    logic [DW-1:0] writeData;
    logic          writeEnable;

    logic [DW-1:0] mem   [512];
    logic [DW-1:0] model [512];
    exp_t          expQ[$];
    int            errors;
    int            checks;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .reqValid     (reqValid),
        .reqWrite     (reqWrite),
        .reqAddr0     (reqAddr0),
        .reqAddr1     (reqAddr1),
        .reqWData0    (reqWData0),
        .reqWData1    (reqWData1),
        .reqReady     (reqReady),
        .rspValid     (rspValid),
        .rspRData     (rspRData),
        .rspErr       (rspErr),
        .readAddress  (readAddress),
        .readData     (readData),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .writeEnable  (writeEnable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // dmem model: combinational read, write on rising edge.
    assign readData = mem[readAddress];
    always @(posedge clk) begin
        if (writeEnable) mem[writeAddress] <= writeData;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the accept edge: predict the response and update the shadow memory.
    task automatic pushExp(input int idx, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.owner = (idx == 1) ? 2'b10 : 2'b01;
        e.err   = BOUNDS && (int'(a) >= DEPTH);
        e.data  = (wr || e.err) ? '0 : model[a];
        if (wr && !e.err) model[a] = d;
        expQ.push_back(e);
    endtask

    // Scoreboard: every response pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (rspValid !== 2'b00) begin
            if (expQ.size() == 0) begin
                chk("spurious_rsp", {62'd0, rspValid}, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("rsp_owner", {62'd0, rspValid}, {62'd0, e.owner});
                chk("rsp_data", {32'd0, rspRData}, {32'd0, e.data});
                chk("rsp_err", {63'd0, rspErr}, {63'd0, e.err});
            end
        end
    end

    task automatic waitReady(input int idx, output bit ok);
        int n;
        n = 0;
        #1;
        while (!reqReady[idx] && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = reqReady[idx];
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    // One full transaction from a single requester with latency checks.
    task automatic doReq(input int idx, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        bit expWe;
        @(negedge clk);
        reqValid[idx] = 1'b1;
        reqWrite[idx] = wr;
        if (idx == 0) begin reqAddr0 = a; reqWData0 = d; end
        else          begin reqAddr1 = a; reqWData1 = d; end
        waitReady(idx, ok);
        if (!ok) begin
            reqValid[idx] = 1'b0;
            return;
        end
        expWe = wr && !(BOUNDS && int'(a) >= DEPTH);
        @(posedge clk);
        pushExp(idx, wr, a, d);
        #1;
        reqValid[idx] = 1'b0;
        @(negedge clk);
        chk("we_t1", {63'd0, writeEnable}, {63'd0, expWe});
        chk("addr_t1", {55'd0, writeAddress}, {55'd0, a});
        if (expWe) chk("wdata_t1", {32'd0, writeData}, {32'd0, d});
        @(negedge clk);
        chk("rsp_t2", {62'd0, rspValid}, (idx == 1) ? 64'd2 : 64'd1);
        chk("we_off_t2", {63'd0, writeEnable}, 64'd0);
    endtask

    initial begin
        bit       ok;
        logic [1:0] g;
        int       served1;
        errors = 0;
        checks = 0;
        for (int i = 0; i < 512; i++) begin
            mem[i]   = '0;
            model[i] = '0;
        end

        // Reset held with both requesters pending contending writes.
        reset_n   = 1'b0;
        reqValid  = 2'b11;
        reqWrite  = 2'b11;
        reqAddr0  = 9'd11;
        reqWData0 = 32'd6789;
        reqAddr1  = 9'd12;
        reqWData1 = 32'd4242;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ready", {62'd0, reqReady}, 64'd0);
            chk("rst_outs", {rspValid, rspRData, rspErr, writeEnable},
                {2'b00, 32'd0, 1'b0, 1'b0});
            chk("rst_mem_side", {readAddress, writeAddress, writeData}, '0);
        end

        // Contention: req0 first (rrPtr=0 after reset), then req1.
        reset_n = 1'b1;
        #1;
        chk("cont_first", {62'd0, reqReady}, 64'd1);
        @(posedge clk);
        pushExp(0, 1'b1, 9'd11, 32'd6789);
        #1;
        reqValid[0] = 1'b0;
        @(negedge clk);
        chk("cont_we0", {writeEnable, writeAddress}, {1'b1, 9'd11});
        waitReady(1, ok);
        chk("cont_second", {62'd0, reqReady}, 64'd2);
        @(posedge clk);
        pushExp(1, 1'b1, 9'd12, 32'd4242);
        #1;
        reqValid[1] = 1'b0;
        @(negedge clk);
        chk("cont_we1", {writeEnable, writeAddress}, {1'b1, 9'd12});
        repeat (2) @(negedge clk);
        doReq(0, 1'b0, 9'd11, '0);
        doReq(1, 1'b0, 9'd12, '0);

        // Single write then read-back.
        doReq(0, 1'b1, 9'd10, 32'd12345);
        doReq(0, 1'b0, 9'd10, '0);
        doReq(1, 1'b0, 9'd10, '0);

        // Starvation: req0 held valid, req1 raised after the third transaction.
        served1 = -1;
        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWrite    = 2'b00;
        reqAddr0    = 9'd1;
        for (int k = 0; k < 10; k++) begin
            #1;
            begin
                int n;
                n = 0;
                while (reqReady == 2'b00 && n < 10) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
            end
            if (reqReady == 2'b00) begin
                chk("starve_timeout", 64'd0, 64'd1);
                break;
            end
            g = reqReady;
            @(posedge clk);
            pushExp(g[1] ? 1 : 0, 1'b0, g[1] ? reqAddr1 : reqAddr0, '0);
            #1;
            if (g[1]) begin
                served1     = k;
                reqValid[1] = 1'b0;
            end
            if (k == 2) begin
                reqValid[1] = 1'b1;
                reqAddr1    = 9'd12;
            end
            reqAddr0 = 9'(k + 2);
            @(negedge clk);
        end
        reqValid = 2'b00;
        checks++;
        assert (served1 == 3 || served1 == 4) else begin
            errors++;
            $error("FAIL starve_served: observed %0d expected 3 or 4", served1);
        end
        repeat (4) @(negedge clk);
        chk("starve_drain", 64'(expQ.size()), 64'd0);

        // Reset during ACCESS discards the write and its response.
        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr0    = 9'd20;
        reqWData0   = 32'd99;
        waitReady(0, ok);
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        reset_n     = 1'b0;
        #1;
        chk("midrst_we", {63'd0, writeEnable}, 64'd0);
        @(negedge clk);
        chk("midrst_rsp_a", {62'd0, rspValid}, 64'd0);
        @(negedge clk);
        chk("midrst_rsp_b", {62'd0, rspValid}, 64'd0);
        reset_n = 1'b1;
        doReq(0, 1'b0, 9'd20, '0);

        // Out-of-range address (only flagged with the bounds check built in).
        doReq(0, 1'b1, 9'd300, 32'd555);
        doReq(1, 1'b0, 9'd300, '0);
        doReq(0, 1'b1, 9'd255, 32'd777);
        doReq(0, 1'b0, 9'd255, '0);

        repeat (4) @(negedge clk);
        chk("final_drain", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
